reg_file_sb: RTL and testbench

- 32-entry general-purpose register file with two combinational read ports, one synchronous write port and a per-register pending-write scoreboard.
- Sits directly upstream of the operand latches (A/B registers). rs_data feeds the A-register input and rt_data feeds the B-register input.
- The write port is driven by the writeback stage. The issue port is driven by decode.
- Produces a stall request when an instruction reads a register whose producer has not yet written back.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 45 ++++
 rtl/reg_file_sb.sv | 60 ++++++
 tb/tb_reg_file_sb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam int unsigned DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_en,
    input  reg_addr_t           issue_addr,
    input  logic                wr_en,
    input  reg_addr_t           wr_addr,
    input  reg_addr_t           rs_addr,
    input  reg_addr_t           rt_addr,
    output logic [NUM_REGS-1:0] pending,
    output logic                rs_pend,
    output logic                rt_pend
);

    logic [NUM_REGS-1:0] pendingNext;

    always_comb begin
        pendingNext = pending;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            // A newly issued producer supersedes one retiring in the same cycle.
            if (issue_en && issue_addr == reg_addr_t'(k)) begin
                pendingNext[k] = 1'b1;
            end else if (wr_en && wr_addr == reg_addr_t'(k)) begin
                pendingNext[k] = 1'b0;
            end
        end
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // A register retiring this cycle is covered by the read bypass, so it does not count.
    assign rs_pend = pending[rs_addr] && !(wr_en && wr_addr == rs_addr);
    assign rt_pend = pending[rt_addr] && !(wr_en && wr_addr == rt_addr);

endmodule

// File: rtl/reg_file_sb.sv
// 32-entry register file with two bypassed combinational read ports and hazard stall.
module reg_file_sb
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  reg_addr_t           rs_addr,
    input  reg_addr_t           rt_addr,
    input  logic                rs_used,
    input  logic                rt_used,
    output word_t               rs_data,
    output word_t               rt_data,
    input  logic                wr_en,
    input  reg_addr_t           wr_addr,
    input  word_t               wr_data,
    input  logic                issue_en,
    input  reg_addr_t           issue_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
);

    word_t regs [NUM_REGS];
    logic  wrLive;
    logic  rsPendEff;
    logic  rtPendEff;

    assign wrLive = wr_en && (wr_addr != ZERO_REG);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrLive) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == ZERO_REG)            ? '0      :
                     (wrLive && wr_addr == rs_addr)   ? wr_data : regs[rs_addr];
    assign rt_data = (rt_addr == ZERO_REG)            ? '0      :
                     (wrLive && wr_addr == rt_addr)   ? wr_data : regs[rt_addr];

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .pending    (pending),
        .rs_pend    (rsPendEff),
        .rt_pend    (rtPendEff)
    );

    assign stall = (rs_used && rsPendEff) || (rt_used && rtPendEff);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, reset sequence, random vs model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr, issue_addr;
    logic        rs_used, rt_used, wr_en, issue_en;
    logic [31:0] wr_data;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [31:0] pending;

    reg_file_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_used    (rs_used),
        .rt_used    (rt_used),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wrEn;
        logic [4:0]  wrAddr;
        logic [31:0] wrData;
        logic        issueEn;
        logic [4:0]  issueAddr;
        logic [4:0]  rsAddr;
        logic        rsUsed;
        logic [4:0]  rtAddr;
        logic        rtUsed;
        logic [31:0] expRs;
        logic [31:0] expRt;
        logic        expStall;
        logic [31:0] expPend;
    } vec_t;

    vec_t tbl [17];

    // Architectural reference state.
    logic [31:0] modelMem [32];
    logic [31:0] modelPend;

    int passed = 0;
    int total  = 0;

    logic [31:0] sRs, sRt, sPend;
    logic        sStall;

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic ie,
                                logic [4:0] ia, logic [4:0] ra, logic ru, logic [4:0] ta,
                                logic tu, logic [31:0] ers, logic [31:0] ert, logic est,
                                logic [31:0] ep);
        vec_t v;
        v.wrEn = we; v.wrAddr = wa; v.wrData = wd; v.issueEn = ie; v.issueAddr = ia;
        v.rsAddr = ra; v.rsUsed = ru; v.rtAddr = ta; v.rtUsed = tu;
        v.expRs = ers; v.expRt = ert; v.expStall = est; v.expPend = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] modelRead(logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return modelMem[a];
    endfunction

    function automatic logic modelStall();
        logic rsHaz, rtHaz;
        rsHaz = modelPend[rs_addr] && !(wr_en && wr_addr == rs_addr);
        rtHaz = modelPend[rt_addr] && !(wr_en && wr_addr == rt_addr);
        return (rs_used && rsHaz) || (rt_used && rtHaz);
    endfunction

    task automatic modelEdge();
        if (reset) begin
            for (int i = 0; i < 32; i++) modelMem[i] = 32'h0;
            modelPend = 32'h0;
        end else begin
            if (wr_en && wr_addr != 0) modelMem[wr_addr] = wr_data;
            if (wr_en) modelPend[wr_addr] = 1'b0;
            if (issue_en) modelPend[issue_addr] = 1'b1;
            modelPend[0] = 1'b0;
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en = v.wrEn; wr_addr = v.wrAddr; wr_data = v.wrData;
        issue_en = v.issueEn; issue_addr = v.issueAddr;
        rs_addr = v.rsAddr; rs_used = v.rsUsed; rt_addr = v.rtAddr; rt_used = v.rtUsed;
    endtask

    // Inputs are driven at negedge; comb outputs sampled 1ns later, pending 1ns after posedge.
    task automatic cycle();
        #1;
        sRs = rs_data; sRt = rt_data; sStall = stall;
        @(posedge clk);
        modelEdge();
        #1;
        sPend = pending;
        @(negedge clk);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) modelMem[i] = 32'hx;
        modelPend = 32'hx;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        check("reset_pending", sPend, 32'h0);

        //           we wa  wdata          ie ia  rs ru rt tu expRs          expRt          st pend
        tbl[0]  = mk(1, 7,  32'h12345678,  0, 0,  7, 0, 7, 0, 32'h12345678, 32'h12345678, 0, 32'h0);
        tbl[1]  = mk(0, 0,  32'h0,         0, 0,  0, 0, 7, 0, 32'h0,        32'h12345678, 0, 32'h0);
        tbl[2]  = mk(1, 0,  32'hFFFFFFFF,  0, 0,  0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
        tbl[3]  = mk(0, 0,  32'h0,         0, 0,  0, 0, 7, 0, 32'h0,        32'h12345678, 0, 32'h0);
        tbl[4]  = mk(1, 9,  32'hA5A5A5A5,  0, 0,  9, 0, 9, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 32'h0);
        tbl[5]  = mk(0, 0,  32'h0,         1, 3,  9, 0, 7, 0, 32'hA5A5A5A5, 32'h12345678, 0, 32'h8);
        tbl[6]  = mk(0, 0,  32'h0,         0, 0,  3, 1, 0, 0, 32'h0,        32'h0,        1, 32'h8);
        tbl[7]  = mk(1, 3,  32'h55,        0, 0,  3, 1, 0, 0, 32'h55,       32'h0,        0, 32'h0);
        tbl[8]  = mk(0, 0,  32'h0,         0, 0,  3, 1, 0, 0, 32'h55,       32'h0,        0, 32'h0);
        tbl[9]  = mk(0, 0,  32'h0,         1, 4,  0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h10);
        tbl[10] = mk(1, 4,  32'h44,        1, 4,  4, 1, 0, 0, 32'h44,       32'h0,        0, 32'h10);
        tbl[11] = mk(0, 0,  32'h0,         0, 0,  4, 1, 0, 0, 32'h44,       32'h0,        1, 32'h10);
        tbl[12] = mk(0, 0,  32'h0,         1, 0,  0, 1, 0, 1, 32'h0,        32'h0,        0, 32'h10);
        tbl[13] = mk(0, 0,  32'h0,         0, 0,  0, 1, 4, 0, 32'h0,        32'h44,       0, 32'h10);
        tbl[14] = mk(0, 0,  32'h0,         0, 0,  0, 0, 4, 1, 32'h0,        32'h44,       1, 32'h10);
        tbl[15] = mk(1, 4,  32'h99,        0, 0,  0, 0, 4, 1, 32'h0,        32'h99,       0, 32'h0);
        tbl[16] = mk(1, 6,  32'h66,        0, 0,  6, 0, 4, 0, 32'h66,       32'h99,       0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            cycle();
            check($sformatf("vec%0d_rs_data", i), sRs, tbl[i].expRs);
            check($sformatf("vec%0d_rt_data", i), sRt, tbl[i].expRt);
            check($sformatf("vec%0d_stall", i), {31'b0, sStall}, {31'b0, tbl[i].expStall});
            check($sformatf("vec%0d_pending", i), sPend, tbl[i].expPend);
        end

        // Reset mid-operation discards the same-cycle write and issue.
        drive(mk(1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();
        check("pre_reset_pending", sPend, 32'h20);
        reset = 1'b1;
        drive(mk(1, 5, 32'h11111111, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();
        reset = 1'b0;
        check("reset_mid_pending", sPend, 32'h0);
        drive(mk(0, 0, 0, 0, 0, 5, 1, 7, 1, 0, 0, 0, 0));
        cycle();
        check("reset_mid_r5", sRs, 32'h0);
        check("reset_mid_r7", sRt, 32'h0);
        check("reset_mid_stall", {31'b0, sStall}, 32'h0);

        // Random traffic on a narrow address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] eRs, eRt;
            logic        eSt;
            logic [4:0]  hi;
            hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            v.wrEn      = $urandom_range(0, 1) == 1;
            v.wrAddr    = 5'($urandom_range(0, int'(hi)));
            v.wrData    = $urandom;
            v.rsAddr    = 5'($urandom_range(0, int'(hi)));
            v.rtAddr    = 5'($urandom_range(0, int'(hi)));
            v.rsUsed    = $urandom_range(0, 1) == 1;
            v.rtUsed    = $urandom_range(0, 1) == 1;
            v.issueEn   = 1'b0;
            v.issueAddr = 5'($urandom_range(0, int'(hi)));
            drive(v);
            #0;
            eSt = modelStall();
            // Decode only issues when not stalled.
            issue_en = !eSt && ($urandom_range(0, 2) == 0);
            eRs = modelRead(rs_addr);
            eRt = modelRead(rt_addr);
            cycle();
            check("rand_rs_data", sRs, eRs);
            check("rand_rt_data", sRt, eRt);
            check("rand_stall", {31'b0, sStall}, {31'b0, eSt});
            check("rand_pending", sPend, modelPend);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
